// File: rtl/stopwatch_bcd_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd_ctrl
//   Start/stop/lap/clear controller for a 2-digit (00-99) BCD stopwatch.
//   A prescaler divides clk into count ticks. Each tick advances a two-digit
//   BCD count. A lap snapshot can be frozen onto the display output while
//   the live count continues.
//
// Parameters
//   TICK_DIV    clk cycles per count increment (>= 1)
//   STOP_AT_99  0: 99 wraps to 00; 1: hold at 99 and auto-pause
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   start_stop   in   1-cycle pulse: toggle run/pause
//   lap          in   1-cycle pulse: freeze/release display
//   clear        in   1-cycle pulse: back to IDLE with count 00
//   count_bcd    out  live count {tens, units}
//   display_bcd  out  lap snapshot while in LAP, otherwise live count
//   running      out  state is RUN or LAP
//   lap_active   out  state is LAP
//   overflow     out  1-cycle pulse on 99->00 wrap or on the 99 hold-stop
// -----------------------------------------------------------------------------
module stopwatch_bcd_ctrl #(
  parameter int TICK_DIV   = 4,
  parameter bit STOP_AT_99 = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [7:0] count_bcd,
  output logic [7:0] display_bcd,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  logic [1:0]    r_state;
  logic [3:0]    r_tens;
  logic [3:0]    r_units;
  logic [7:0]    r_lap;
  logic [PW-1:0] r_presc;
  logic          r_ovf;

  logic [1:0]    w_state_nxt;
  logic [3:0]    w_tens_nxt;
  logic [3:0]    w_units_nxt;
  logic [7:0]    w_lap_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_ovf_nxt;

  logic w_running;
  logic w_tick;
  logic w_at_99;

  assign w_running = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick    = w_running && (r_presc == PRESC_LAST);
  assign w_at_99   = (r_tens == 4'd9) && (r_units == 4'd9);

  always_comb begin
    w_state_nxt = r_state;
    w_tens_nxt  = r_tens;
    w_units_nxt = r_units;
    w_lap_nxt   = r_lap;
    w_presc_nxt = r_presc;
    w_ovf_nxt   = 1'b0;

    if (clear) begin
      w_state_nxt = S_IDLE;
      w_tens_nxt  = '0;
      w_units_nxt = '0;
      w_presc_nxt = '0;
    end else begin
      // Prescaler only advances while running; it holds in PAUSE so a
      // resume continues the interrupted tick phase.
      if (w_running) begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
      end

      // start_stop outranks lap; a simultaneous lap pulse is dropped.
      if (start_stop) begin
        case (r_state)
          S_IDLE: begin
            w_state_nxt = S_RUN;
            w_presc_nxt = '0;
          end
          S_RUN:   w_state_nxt = S_PAUSE;
          S_PAUSE: w_state_nxt = S_RUN;
          S_LAP:   w_state_nxt = S_PAUSE;
          default: w_state_nxt = S_IDLE;
        endcase
      end else if (lap) begin
        if (r_state == S_RUN) begin
          w_state_nxt = S_LAP;
          w_lap_nxt   = {r_tens, r_units};
        end else if (r_state == S_LAP) begin
          w_state_nxt = S_RUN;
        end
      end

      // Increment is applied regardless of a same-edge start_stop or lap;
      // the snapshot above already captured the pre-increment value.
      if (w_tick) begin
        if (w_at_99) begin
          w_ovf_nxt = 1'b1;
          if (STOP_AT_99) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_tens_nxt  = '0;
            w_units_nxt = '0;
          end
        end else if (r_units == 4'd9) begin
          w_units_nxt = '0;
          w_tens_nxt  = r_tens + 4'd1;
        end else begin
          w_units_nxt = r_units + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tens  <= '0;
      r_units <= '0;
      r_lap   <= '0;
      r_presc <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tens  <= w_tens_nxt;
      r_units <= w_units_nxt;
      r_lap   <= w_lap_nxt;
      r_presc <= w_presc_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count_bcd   = {r_tens, r_units};
  assign lap_active  = (r_state == S_LAP);
  assign display_bcd = lap_active ? r_lap : count_bcd;
  assign running     = w_running;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_bcd_ctrl
//   Three instances share one stimulus stream:
//     0: TICK_DIV=4, wrap at 99
//     1: TICK_DIV=4, hold-stop at 99
//     2: TICK_DIV=1, wrap at 99
//   A behavioural stopwatch model (integer count, named states) predicts every
//   output of every instance each cycle; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_stopwatch_bcd_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  typedef struct {
    int st;
    int cnt;
    int lapv;
    int ph;
    bit ovf;
  } mdl_t;

  logic clk = 1'b0;
  logic reset;
  logic start_stop;
  logic lap;
  logic clear;

  logic [7:0] cnt [3];
  logic [7:0] dsp [3];
  logic       run [3];
  logic       lapa[3];
  logic       ovf [3];

  int   vectors     = 0;
  int   miscompares = 0;
  bit   chk_en      = 1'b0;
  mdl_t m[3];
  int   divs  [3] = '{4, 4, 1};
  bit   stop99[3] = '{1'b0, 1'b1, 1'b0};

  stopwatch_bcd_ctrl #(.TICK_DIV(4), .STOP_AT_99(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .count_bcd(cnt[0]), .display_bcd(dsp[0]), .running(run[0]),
    .lap_active(lapa[0]), .overflow(ovf[0])
  );

  stopwatch_bcd_ctrl #(.TICK_DIV(4), .STOP_AT_99(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .count_bcd(cnt[1]), .display_bcd(dsp[1]), .running(run[1]),
    .lap_active(lapa[1]), .overflow(ovf[1])
  );

  stopwatch_bcd_ctrl #(.TICK_DIV(1), .STOP_AT_99(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .count_bcd(cnt[2]), .display_bcd(dsp[2]), .running(run[2]),
    .lap_active(lapa[2]), .overflow(ovf[2])
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // One clock edge of the stopwatch as described behaviourally.
  function automatic mdl_t step(input mdl_t x, input int div, input bit s99,
                                input bit ss, input bit lp, input bit clr);
    mdl_t n;
    bit   going;
    bit   tick;
    n     = x;
    n.ovf = 1'b0;
    going = (x.st == M_RUN) || (x.st == M_LAP);
    tick  = going && (x.ph == div - 1);
    if (clr) begin
      n.st  = M_IDLE;
      n.cnt = 0;
      n.ph  = 0;
      return n;
    end
    if (going) n.ph = (x.ph + 1) % div;
    if (ss) begin
      if (x.st == M_IDLE) begin
        n.st = M_RUN;
        n.ph = 0;
      end else if (x.st == M_PAUSE) n.st = M_RUN;
      else n.st = M_PAUSE;
    end else if (lp) begin
      if (x.st == M_RUN) begin
        n.st   = M_LAP;
        n.lapv = x.cnt;
      end else if (x.st == M_LAP) n.st = M_RUN;
    end
    if (tick) begin
      if (x.cnt == 99) begin
        n.ovf = 1'b1;
        if (s99) n.st = M_PAUSE;
        else n.cnt = 0;
      end else begin
        n.cnt = x.cnt + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [18:0] expv(input mdl_t x);
    bit in_lap;
    in_lap = (x.st == M_LAP);
    return {bcd(x.cnt), in_lap ? bcd(x.lapv) : bcd(x.cnt),
            (x.st == M_RUN) || in_lap, in_lap, x.ovf};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) m[i] = '{0, 0, 0, 0, 1'b0};
      else m[i] = step(m[i], divs[i], stop99[i], start_stop, lap, clear);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_dut%0d", i),
            {13'b0, cnt[i], dsp[i], run[i], lapa[i], ovf[i]},
            {13'b0, expv(m[i])});
      end
    end
  end

  // One clock edge with the given pulses; returns just after that edge.
  task automatic cyc(input bit ss, input bit lp, input bit clr);
    @(negedge clk);
    start_stop = ss;
    lap        = lp;
    clear      = clr;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", cnt[0], 8'h00);
    chk("reset_running", run[0], 1'b0);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Start and first increments
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_running", run[0], 1'b1);
    chk("start_count_e0", cnt[0], 8'h00);
    idle(3);
    chk("count_e3", cnt[0], 8'h00);
    idle(1);
    chk("count_e4", cnt[0], 8'h01);
    idle(4);
    chk("count_e8", cnt[0], 8'h02);

    // Digit carry and end-of-range behaviour
    idle(28);
    chk("count_09", cnt[0], 8'h09);
    idle(4);
    chk("carry_10", cnt[0], 8'h10);
    idle(356);
    chk("count_99", cnt[0], 8'h99);
    chk("no_ovf_at_99", ovf[0], 1'b0);
    idle(4);
    chk("wrap_00", cnt[0], 8'h00);
    chk("wrap_ovf", ovf[0], 1'b1);
    chk("hold_99", cnt[1], 8'h99);
    chk("hold_paused", run[1], 1'b0);
    chk("hold_ovf", ovf[1], 1'b1);
    idle(1);
    chk("wrap_ovf_gone", ovf[0], 1'b0);
    chk("hold_ovf_gone", ovf[1], 1'b0);
    cyc(1'b0, 1'b0, 1'b1);

    // Lap snapshot
    cyc(1'b1, 1'b0, 1'b0);
    idle(92);
    chk("pre_lap_23", cnt[0], 8'h23);
    cyc(1'b0, 1'b1, 1'b0);
    chk("lap_active", lapa[0], 1'b1);
    chk("lap_disp_23", dsp[0], 8'h23);
    idle(15);
    chk("lap_count_27", cnt[0], 8'h27);
    chk("lap_frozen_23", dsp[0], 8'h23);
    cyc(1'b0, 1'b1, 1'b0);
    chk("lap_release", lapa[0], 1'b0);
    chk("lap_release_disp", dsp[0], 8'h27);

    // start_stop with lap pauses; phase resumes at held prescaler value 2
    cyc(1'b1, 1'b1, 1'b0);
    chk("ss_lap_pause", run[0], 1'b0);
    chk("ss_lap_nolap", lapa[0], 1'b0);
    idle(3);
    chk("pause_hold", cnt[0], 8'h27);
    cyc(1'b1, 1'b0, 1'b0);
    chk("resume_run", run[0], 1'b1);
    idle(1);
    chk("resume_e1", cnt[0], 8'h27);
    idle(1);
    chk("resume_e2", cnt[0], 8'h28);

    // Clear from LAP
    idle(120);
    chk("pre_clear_58", cnt[0], 8'h58);
    cyc(1'b0, 1'b1, 1'b0);
    chk("lap_58", dsp[0], 8'h58);
    cyc(1'b0, 1'b0, 1'b1);
    chk("clear_count", cnt[0], 8'h00);
    chk("clear_disp", dsp[0], 8'h00);
    chk("clear_running", run[0], 1'b0);
    chk("clear_lap", lapa[0], 1'b0);

    // Asynchronous reset mid-run
    cyc(1'b1, 1'b0, 1'b0);
    idle(148);
    chk("pre_reset_37", cnt[0], 8'h37);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_outs", {cnt[0], dsp[0], run[0], lapa[0], ovf[0]}, 19'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(5);
    chk("post_rst_idle", run[0], 1'b0);
    chk("post_rst_count", cnt[0], 8'h00);
    chk("post_rst_ovf", ovf[0], 1'b0);

    // Randomized traffic, checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 299) == 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
